// File: rtl/pattern_gen_ew_if.sv
// Control inputs and PATTRN_* event-window outputs of the synthetic pattern generator.
// Latency: wiring only. Backpressure: ew_fifo_full travels generator-ward; no ready signal is carried.
// Ports: master = generator (drives PATTRN_*), slave = output mux / test control (drives start, init, config, full).
interface pattern_gen_ew_if #(
  parameter int DATA_W = 32,
  parameter int SIZE_W = 10,
  parameter int TAG_W  = 20
);
  logic              PATTRN_axi_start_on_serdesclk;
  logic              pattern_init;
  logic [TAG_W-1:0]  init_tag;
  logic [7:0]        hit_count;
  logic [1:0]        pattern_type;
  logic              ew_fifo_full;

  logic              PATTRN_curr_ewfifo_wr;
  logic              PATTRN_ew_fifo_we;
  logic [DATA_W-1:0] PATTRN_ew_fifo_data;
  logic              PATTRN_ew_done;
  logic [SIZE_W-1:0] PATTRN_ew_size;
  logic [TAG_W-1:0]  PATTRN_ew_tag;
  logic              PATTRN_ew_ovfl;
  logic              PATTRN_ew_tag_error;
  logic              PATTRN_tag_sync_error;

  modport master (
    input  PATTRN_axi_start_on_serdesclk, pattern_init, init_tag, hit_count, pattern_type, ew_fifo_full,
    output PATTRN_curr_ewfifo_wr, PATTRN_ew_fifo_we, PATTRN_ew_fifo_data, PATTRN_ew_done,
           PATTRN_ew_size, PATTRN_ew_tag, PATTRN_ew_ovfl, PATTRN_ew_tag_error, PATTRN_tag_sync_error
  );

  modport slave (
    output PATTRN_axi_start_on_serdesclk, pattern_init, init_tag, hit_count, pattern_type, ew_fifo_full,
    input  PATTRN_curr_ewfifo_wr, PATTRN_ew_fifo_we, PATTRN_ew_fifo_data, PATTRN_ew_done,
           PATTRN_ew_size, PATTRN_ew_tag, PATTRN_ew_ovfl, PATTRN_ew_tag_error, PATTRN_tag_sync_error
  );
endinterface

// File: rtl/pattern_gen_ew.sv
// Synthetic event-window source: per start pulse, emits hit_count deterministic hit words then a done/status pulse.
// Latency: first word one cycle after start; done one cycle after the last word (one cycle after start if empty).
// Backpressure: ew_fifo_full drops (not stalls) the word being issued and flags the window as overflowed.
// Ports: serdesclk / reset_serdesclk (async, active high); ew = control in + PATTRN_* outputs, all registered.
module pattern_gen_ew #(
  parameter int DATA_W = 32,
  parameter int SIZE_W = 10,
  parameter int TAG_W  = 20
) (
  input  logic             serdesclk,
  input  logic             reset_serdesclk,
  pattern_gen_ew_if.master ew
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GEN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;        // next word index to issue
  logic [7:0]        hc_q, hc_d;
  logic [1:0]        type_q, type_d;
  logic [TAG_W-1:0]  tag_q, tag_d;        // tag of the current/next window
  logic [8:0]        wr_cnt_q, wr_cnt_d;  // words actually written this window
  logic              win_ovfl_q, win_ovfl_d;
  logic              pend_q, pend_d;

  logic              curr_q, curr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [TAG_W-1:0]  etag_q, etag_d;
  logic              ovfl_q, ovfl_d;
  logic              terr_q, terr_d;
  logic              serr_q, serr_d;

  logic              init_ok;
  logic [TAG_W-1:0]  tag_win;
  logic              start_go;
  logic [8:0]        wr_base;
  logic              issue, close, close_terr;
  logic [7:0]        issue_idx;
  logic [1:0]        issue_type;

  function automatic logic [DATA_W-1:0] gen_word(input logic [1:0] typ, input logic [7:0] idx,
                                                 input logic [TAG_W-1:0] tag);
    logic [DATA_W-1:0] w;
    case (typ)
      2'd0:    w = DATA_W'({16'(tag), 8'h00, idx});
      2'd1:    w = DATA_W'(1) << (32'(idx) % DATA_W);
      2'd2:    w = DATA_W'(32'hA5A5A5A5) ^ DATA_W'(idx);
      default: w = ~DATA_W'(idx);
    endcase
    return w;
  endfunction

  // An init arriving with a start in IDLE takes effect first, so the window carries init_tag.
  assign init_ok  = ew.pattern_init && (state_q == S_IDLE);
  assign tag_win  = init_ok ? ew.init_tag : tag_q;
  assign start_go = ew.PATTRN_axi_start_on_serdesclk || ((state_q == S_DONE) && pend_q);
  // Counters only carry over while generating; a new or empty window starts from zero.
  assign wr_base  = (state_q == S_GEN) ? wr_cnt_q : 9'd0;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hc_d       = hc_q;
    type_d     = type_q;
    tag_d      = tag_q;
    wr_cnt_d   = wr_cnt_q;
    win_ovfl_d = win_ovfl_q;
    pend_d     = pend_q;
    curr_d     = curr_q;
    we_d       = 1'b0;
    data_d     = data_q;
    done_d     = 1'b0;
    size_d     = size_q;
    etag_d     = etag_q;
    ovfl_d     = ovfl_q;
    terr_d     = terr_q;
    serr_d     = serr_q;
    issue      = 1'b0;
    issue_idx  = idx_q;
    issue_type = type_q;
    close      = 1'b0;
    close_terr = 1'b0;

    if (ew.pattern_init) begin
      if (init_ok) begin
        tag_d  = ew.init_tag;
        serr_d = 1'b0;
      end else begin
        serr_d = 1'b1;
      end
    end

    case (state_q)
      S_GEN: begin
        // A start here (including alongside the last word) aborts the window and queues the next one.
        if (ew.PATTRN_axi_start_on_serdesclk) begin
          close      = 1'b1;
          close_terr = 1'b1;
          pend_d     = 1'b1;
        end else if (idx_q == hc_q) begin
          close = 1'b1;
        end else begin
          issue = 1'b1;
          idx_d = idx_q + 8'd1;
        end
      end
      default: begin  // IDLE or DONE; a start seen in DONE is taken straight away
        state_d = S_IDLE;
        pend_d  = 1'b0;
        if (start_go) begin
          curr_d     = ~curr_q;
          hc_d       = ew.hit_count;
          type_d     = ew.pattern_type;
          wr_cnt_d   = 9'd0;
          win_ovfl_d = 1'b0;
          if (ew.hit_count == 8'd0) begin
            close = 1'b1;
          end else begin
            // Word 0 is issued on the accepting edge so it appears in the first cycle after start.
            issue      = 1'b1;
            issue_idx  = 8'd0;
            issue_type = ew.pattern_type;
            idx_d      = 8'd1;
            state_d    = S_GEN;
          end
        end
      end
    endcase

    // Full is sampled on the issuing edge; a dropped word still consumes its index.
    if (issue) begin
      data_d = gen_word(issue_type, issue_idx, tag_win);
      we_d   = ~ew.ew_fifo_full;
      if (ew.ew_fifo_full) begin
        win_ovfl_d = 1'b1;
      end else begin
        wr_cnt_d = wr_base + 9'd1;
      end
    end

    if (close) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      size_d  = SIZE_W'((10'(wr_base) + 10'd1) >> 1);  // 32-bit words to 64-bit beats, rounded up
      etag_d  = tag_win;
      ovfl_d  = (state_q == S_GEN) ? win_ovfl_q : 1'b0;
      terr_d  = close_terr;
      tag_d   = tag_win + TAG_W'(1);
    end
  end

  always_ff @(posedge serdesclk or posedge reset_serdesclk) begin
    if (reset_serdesclk) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hc_q       <= '0;
      type_q     <= '0;
      tag_q      <= '0;
      wr_cnt_q   <= '0;
      win_ovfl_q <= 1'b0;
      pend_q     <= 1'b0;
      curr_q     <= 1'b0;
      we_q       <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      size_q     <= '0;
      etag_q     <= '0;
      ovfl_q     <= 1'b0;
      terr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hc_q       <= hc_d;
      type_q     <= type_d;
      tag_q      <= tag_d;
      wr_cnt_q   <= wr_cnt_d;
      win_ovfl_q <= win_ovfl_d;
      pend_q     <= pend_d;
      curr_q     <= curr_d;
      we_q       <= we_d;
      data_q     <= data_d;
      done_q     <= done_d;
      size_q     <= size_d;
      etag_q     <= etag_d;
      ovfl_q     <= ovfl_d;
      terr_q     <= terr_d;
      serr_q     <= serr_d;
    end
  end

  assign ew.PATTRN_curr_ewfifo_wr = curr_q;
  assign ew.PATTRN_ew_fifo_we     = we_q;
  assign ew.PATTRN_ew_fifo_data   = data_q;
  assign ew.PATTRN_ew_done        = done_q;
  assign ew.PATTRN_ew_size        = size_q;
  assign ew.PATTRN_ew_tag         = etag_q;
  assign ew.PATTRN_ew_ovfl        = ovfl_q;
  assign ew.PATTRN_ew_tag_error   = terr_q;
  assign ew.PATTRN_tag_sync_error = serr_q;
endmodule

// File: tb/tb_pattern_gen_ew.sv
// Bench for pattern_gen_ew: windows are driven cycle by cycle, expected words/done records are queued
// with the cycle they must appear in, and a negedge monitor pops and compares them.
module tb_pattern_gen_ew;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 10;
  localparam int TAG_W  = 20;

  logic serdesclk = 1'b0;
  logic reset_serdesclk = 1'b1;

  pattern_gen_ew_if #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .TAG_W(TAG_W)) bus ();

  pattern_gen_ew #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .TAG_W(TAG_W)) dut (
    .serdesclk      (serdesclk),
    .reset_serdesclk(reset_serdesclk),
    .ew             (bus)
  );

  always #5 serdesclk = ~serdesclk;

  typedef struct { int cyc; logic [31:0] dat; } wexp_t;
  typedef struct { int cyc; int size; int tag; bit ovfl; bit terr; bit curr; } dexp_t;

  wexp_t exp_w[$];
  dexp_t exp_d[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  int    mtag = 0;
  bit    mcurr = 1'b0;
  bit    mserr = 1'b0;

  always @(posedge serdesclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Hit word straight from the pattern rules.
  function automatic logic [31:0] mword(input int k, input int typ, input int tag);
    logic [31:0] kv;
    logic [31:0] tv;
    kv = 32'(k);
    tv = 32'(tag);
    case (typ)
      0:       return {tv[15:0], kv[15:0]};
      1:       return 32'd1 << (k % 32);
      2:       return 32'hA5A5A5A5 ^ kv;
      default: return ~kv;
    endcase
  endfunction

  always @(negedge serdesclk) begin
    if (mon_en && !reset_serdesclk) begin
      wexp_t w;
      dexp_t d;
      bit    we_exp;
      bit    dn_exp;
      we_exp = (exp_w.size() > 0) && (exp_w[0].cyc == cyc);
      chk("we", 64'(bus.PATTRN_ew_fifo_we), 64'(we_exp));
      if (we_exp) begin
        w = exp_w.pop_front();
        if (bus.PATTRN_ew_fifo_we) chk("data", 64'(bus.PATTRN_ew_fifo_data), 64'(w.dat));
      end
      dn_exp = (exp_d.size() > 0) && (exp_d[0].cyc == cyc);
      chk("done", 64'(bus.PATTRN_ew_done), 64'(dn_exp));
      if (dn_exp) begin
        d = exp_d.pop_front();
        if (bus.PATTRN_ew_done) begin
          chk("size", 64'(bus.PATTRN_ew_size), 64'(d.size));
          chk("tag", 64'(bus.PATTRN_ew_tag), 64'(d.tag));
          chk("ovfl", 64'(bus.PATTRN_ew_ovfl), 64'(d.ovfl));
          chk("tag_error", 64'(bus.PATTRN_ew_tag_error), 64'(d.terr));
          chk("curr_wr", 64'(bus.PATTRN_curr_ewfifo_wr), 64'(d.curr));
        end
      end
    end
  end

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.PATTRN_axi_start_on_serdesclk = 1'b0;
      bus.pattern_init = 1'b0;
      bus.ew_fifo_full = 1'($urandom_range(1));
      @(posedge serdesclk); #1;
    end
    bus.ew_fifo_full = 1'b0;
  endtask

  // Drives one window starting in the current cycle. abort_at>0: second start at that offset.
  // pending: the window is the queued one after an abort (no fresh start needed).
  // idle: DUT is in IDLE this cycle. init_at: offset of a pattern_init pulse (-1 none).
  task automatic run_window(input int hc, input int typ, input int abort_at, input logic [31:0] fmask,
                            input int full_pct, input bit pending, input bit idle,
                            input int init_at, input int itag);
    int    n_issue, done_off, wr, n0, tagw;
    bit    ov, fl;
    wexp_t w;
    dexp_t d;
    n0       = cyc;
    n_issue  = (abort_at > 0) ? abort_at : hc;
    done_off = (abort_at > 0) ? abort_at + 1 : ((hc == 0) ? 1 : hc + 1);
    wr = 0;
    ov = 1'b0;
    if (init_at == 0) begin
      if (idle) begin
        mtag  = itag;
        mserr = 1'b0;
      end else begin
        mserr = 1'b1;
      end
    end
    tagw  = mtag;
    mcurr = ~mcurr;
    for (int j = 0; j < done_off; j++) begin
      if (j == 0) begin
        bus.PATTRN_axi_start_on_serdesclk = pending ? 1'($urandom_range(1)) : 1'b1;
        bus.hit_count    = 8'(hc);
        bus.pattern_type = 2'(typ);
      end else begin
        bus.PATTRN_axi_start_on_serdesclk = (j == abort_at);
        bus.hit_count    = 8'($urandom);
        bus.pattern_type = 2'($urandom);
      end
      bus.pattern_init = (j == init_at);
      bus.init_tag     = (j == init_at) ? 20'(itag) : 20'($urandom);
      fl = ((j < 32) ? fmask[j] : 1'b0) || ($urandom_range(99) < full_pct);
      bus.ew_fifo_full = fl;
      if (j < n_issue) begin
        if (fl) begin
          ov = 1'b1;
        end else begin
          w.cyc = n0 + j + 1;
          w.dat = mword(j, typ, tagw);
          exp_w.push_back(w);
          wr++;
        end
      end
      @(posedge serdesclk); #1;
    end
    if (init_at > 0) mserr = 1'b1;
    d.cyc  = n0 + done_off;
    d.size = (wr + 1) / 2;
    d.tag  = tagw;
    d.ovfl = ov;
    d.terr = (abort_at > 0);
    d.curr = mcurr;
    exp_d.push_back(d);
    mtag = (mtag + 1) % (1 << TAG_W);
    bus.PATTRN_axi_start_on_serdesclk = 1'b0;
    bus.pattern_init = 1'b0;
    bus.ew_fifo_full = 1'b0;
    chk("sync_error", 64'(bus.PATTRN_tag_sync_error), 64'(mserr));
  endtask

  task automatic chk_all_zero(input string tagname);
    chk({tagname, "_we"},   64'(bus.PATTRN_ew_fifo_we), 64'd0);
    chk({tagname, "_data"}, 64'(bus.PATTRN_ew_fifo_data), 64'd0);
    chk({tagname, "_done"}, 64'(bus.PATTRN_ew_done), 64'd0);
    chk({tagname, "_curr"}, 64'(bus.PATTRN_curr_ewfifo_wr), 64'd0);
    chk({tagname, "_size"}, 64'(bus.PATTRN_ew_size), 64'd0);
    chk({tagname, "_tag"},  64'(bus.PATTRN_ew_tag), 64'd0);
    chk({tagname, "_ovfl"}, 64'(bus.PATTRN_ew_ovfl), 64'd0);
    chk({tagname, "_terr"}, 64'(bus.PATTRN_ew_tag_error), 64'd0);
    chk({tagname, "_serr"}, 64'(bus.PATTRN_tag_sync_error), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hc, typ, ab, ia;
    bit  pend, idle_now;
    bus.PATTRN_axi_start_on_serdesclk = 1'b0;
    bus.pattern_init = 1'b0;
    bus.init_tag     = '0;
    bus.hit_count    = '0;
    bus.pattern_type = '0;
    bus.ew_fifo_full = 1'b0;
    repeat (3) @(posedge serdesclk);
    #1;
    chk_all_zero("reset");
    reset_serdesclk = 1'b0;
    @(posedge serdesclk); #1;
    mon_en = 1'b1;

    // Directed windows
    run_window(4, 0, 0, 32'h0, 0, 1'b0, 1'b1, -1, 0);        // data 0..3, size 2, tag 0
    gap(2);
    run_window(3, 2, 0, 32'h4, 0, 1'b0, 1'b1, -1, 0);        // one drop -> size 1, ovfl
    gap(1);
    run_window(3, 2, 0, 32'h0, 0, 1'b0, 1'b1, -1, 0);        // ovfl cleared
    gap(1);
    run_window(0, 1, 0, 32'h0, 0, 1'b0, 1'b1, -1, 0);        // empty window
    gap(1);
    run_window(10, 1, 3, 32'h0, 0, 1'b0, 1'b1, -1, 0);       // aborted at N+3
    run_window(5, 3, 0, 32'h0, 0, 1'b1, 1'b0, -1, 0);        // queued window
    gap(2);
    run_window(1, 0, 0, 32'h0, 0, 1'b0, 1'b1, 0, 'hFFFFF);   // init in IDLE
    gap(1);
    run_window(1, 0, 0, 32'h0, 0, 1'b0, 1'b1, -1, 0);        // tag wraps to 0
    gap(1);
    run_window(6, 0, 0, 32'h0, 0, 1'b0, 1'b1, 3, 'h12345);   // init rejected mid-window
    gap(1);
    run_window(2, 0, 0, 32'h0, 0, 1'b0, 1'b1, 0, 'h00ABC);   // accepted init clears sticky error
    run_window(3, 1, 0, 32'h0, 0, 1'b0, 1'b0, -1, 0);        // start during DONE
    gap(1);

    // Randomized windows
    pend = 1'b0;
    idle_now = 1'b1;
    for (int i = 0; i < 40; i++) begin
      hc  = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12));
      typ = int'($urandom_range(3));
      ab  = (hc > 0 && $urandom_range(4) == 0) ? int'($urandom_range(hc, 1)) : 0;
      ia  = -1;
      if ($urandom_range(7) == 0) ia = 0;
      else if (hc > 0 && $urandom_range(7) == 0) ia = 1;
      run_window(hc, typ, ab, 32'h0, 25, pend, idle_now, ia, int'($urandom & 32'hFFFFF));
      pend = (ab > 0);
      if (!pend && $urandom_range(1) == 1) begin
        gap(int'($urandom_range(3, 1)));
        idle_now = 1'b1;
      end else begin
        idle_now = 1'b0;
      end
    end
    if (pend) run_window(2, 0, 0, 32'h0, 0, 1'b1, 1'b0, -1, 0);
    gap(1);

    // Reset in the middle of a window, with the sticky sync error set beforehand
    run_window(5, 2, 0, 32'h0, 0, 1'b0, 1'b1, 2, 'h55555);
    gap(1);
    mon_en = 1'b0;
    bus.PATTRN_axi_start_on_serdesclk = 1'b1;
    bus.hit_count    = 8'd8;
    bus.pattern_type = 2'd0;
    @(posedge serdesclk); #1;
    bus.PATTRN_axi_start_on_serdesclk = 1'b0;
    @(posedge serdesclk); #1;
    chk("pre_reset_we", 64'(bus.PATTRN_ew_fifo_we), 64'd1);
    reset_serdesclk = 1'b1;
    @(posedge serdesclk); #1;
    chk_all_zero("mid_reset");
    reset_serdesclk = 1'b0;
    mtag  = 0;
    mcurr = 1'b0;
    mserr = 1'b0;
    @(posedge serdesclk); #1;
    mon_en = 1'b1;
    run_window(4, 0, 0, 32'h0, 0, 1'b0, 1'b1, -1, 0);        // behaves as after power-up
    gap(5);

    chk("words_drained", 64'(exp_w.size()), 64'd0);
    chk("dones_drained", 64'(exp_d.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
